audio_dac_tx: RTL and testbench
===============================

Name: audio_dac_tx

Overview:
- Transmit end of the codec audio path: takes parallel stereo samples from the processing chain (delay/effects output) and serialises them to the codec DAC as I2S.
- Generates BCLK, LRCLK and DACDAT from the single system clock.
- Issues a per-frame sample request strobe, which upstream uses as its sample-rate tick.
- Holds samples in a one-deep valid/ready holding register so upstream timing is decoupled from the frame.

Parameters:
- DATA_WIDTH, 16, sample width in bits (signed two's complement).
- SLOT_BITS, 32, BCLK periods per channel slot. Must be >= DATA_WIDTH+1.
- BCLK_DIV, 4, clk cycles per BCLK half-period. Must be >= 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- audio_left_in  input  DATA_WIDTH  signed left sample.
- audio_right_in  input  DATA_WIDTH  signed right sample.
- sample_valid  input  1  upstream presents a sample pair.
- sample_ready  output  1  holding register empty; pair accepted when valid&&ready.
- sample_req  output  1  one-clk pulse at each frame start.
- underrun  output  1  one-clk pulse when a frame starts with the holding register empty.
- bclk  output  1  codec bit clock.
- lrclk  output  1  codec word clock: 0 = left slot, 1 = right slot.
- dacdat  output  1  serial data, MSB first.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - Outputs: bclk=0, lrclk=0, dacdat=0, sample_ready=1, sample_req=0, underrun=0.
  - Internal state: div counter=0, bit_cnt=0, holding register empty, shift data=0.
  - Reset asserted mid-frame aborts the frame immediately. No partial-word completion.
- BCLK generation:
  - Div counter runs 0..BCLK_DIV-1. At the terminal count it wraps and bclk toggles.
  - First rising edge occurs BCLK_DIV cycles after reset release; BCLK period is 2*BCLK_DIV clk cycles.
- Falling-edge events (the clk cycle in which bclk goes 1->0):
  - bit_cnt advances mod 2*SLOT_BITS; dacdat and lrclk update in the same cycle.
  - Codec samples dacdat on the BCLK rising edge.
  - lrclk = (bit_cnt >= SLOT_BITS). Slot bit index k = bit_cnt mod SLOT_BITS.
- Data placement (I2S, one-bit delay):
  - k=0: dacdat carries the previous slot's trailing 0.
  - k=1..DATA_WIDTH: dacdat = sample[DATA_WIDTH-k].
  - k>DATA_WIDTH: dacdat = 0.
  - The left word is used in the left slot, the right word in the right slot.
- Frame start: the falling edge where bit_cnt wraps 2*SLOT_BITS-1 -> 0.
  - sample_req pulses for exactly that clk cycle.
  - If the holding register is full: its pair moves to the shift/output words, the register empties, and sample_ready=1 on the next cycle.
  - If the holding register is empty: the output words become zero for the whole frame and underrun pulses in the same cycle as sample_req.
  - The first frame after reset transmits zeros with no load event, so neither sample_req nor underrun pulses for it.
- Handshake:
  - An accept (valid&&ready) captures both inputs; sample_ready drops the next cycle.
  - Inputs are ignored while sample_ready=0.
  - Valid may be held with no combinational path to ready.
- Simultaneous accept and frame start: the frame-start load sees the pre-edge (empty) register, so underrun pulses and zeros are sent. The accepted pair is kept for the next frame.
- Latency: a pair accepted before frame start N reaches dacdat as left MSB at the first falling edge after frame start N (k=1).
- Arithmetic: no scaling or saturation; samples are passed through bit-exact.

Optional Feature:
- Macro: AUDIO_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format, with no one-bit delay.
  - k=0..DATA_WIDTH-1: dacdat = sample[DATA_WIDTH-1-k].
  - k>=DATA_WIDTH: dacdat = 0.
  - Relaxed constraint: SLOT_BITS >= DATA_WIDTH.
- Undefined: I2S placement as above.
- Clocking, handshake and underrun behaviour are identical in both modes.

Test Plan:
- Run with DATA_WIDTH=16, SLOT_BITS=32, BCLK_DIV=2.
- Reset then idle 600 clks:
  - bclk period = 4 clks and lrclk period = 256 clks.
  - dacdat=0 throughout; sample_ready=1.
  - First sample_req at clk 256, with underrun pulsing together.
- Accept left=16'h8001, right=16'h7FFE before the first frame start:
  - Left slot bits k=1..16 = 1000_0000_0000_0001; k=17..31 = 0.
  - Right slot bits k=1..16 = 0111_1111_1111_1110.
  - No underrun.
- Hold sample_valid=1 continuously with a new pair each accept:
  - Exactly one accept per frame; sample_ready low between accept and frame start.
  - No underrun over 10 frames.
- Present sample_valid on the exact frame-start cycle with the register empty:
  - underrun pulses and the frame is all zeros.
  - That pair is transmitted in the following frame.
- Assert rst_n=0 for 1 clk mid right slot:
  - Next cycle bclk=0, lrclk=0, dacdat=0, sample_ready=1.
  - The frame restarts from bit_cnt=0.
- With AUDIO_TX_LEFT_JUSTIFIED_EN and left=16'hA5A5:
  - Left slot k=0..15 = 1010_0101_1010_0101.
  - The MSB coincides with the lrclk 1->0 falling edge.

Source files
------------

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: I2S transmitter for the codec DAC path.
// Accepts stereo sample pairs through a one-deep valid/ready holding register,
// derives BCLK/LRCLK from the system clock and shifts each word out MSB first.
// Optional feature macro: AUDIO_TX_LEFT_JUSTIFIED_EN selects left-justified
// placement (no one-bit delay) instead of I2S placement.
module audio_dac_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] audio_left_in,
    input  logic [DATA_WIDTH-1:0] audio_right_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  sample_req,
    output logic                  underrun,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  dacdat
);

    // Counter widths; a divider of 1 still needs a one-bit counter.
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0]      SLOT_LEN = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0]      WORD_LEN = CNT_W'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] TOP_BIT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Bit clock divider
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             bclk_q, bclk_d;
    logic             divTerm;
    logic             fallEdge;

    // Frame position
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic             frameStart;

    // Holding register (upstream side)
    logic                  holdFull_q, holdFull_d;
    logic [DATA_WIDTH-1:0] holdLeft_q, holdLeft_d;
    logic [DATA_WIDTH-1:0] holdRight_q, holdRight_d;
    logic                  accept;

    // Words being transmitted in the current frame
    logic [DATA_WIDTH-1:0] txLeft_q, txLeft_d;
    logic [DATA_WIDTH-1:0] txRight_q, txRight_d;

    // Registered strobes and serial outputs
    logic sampleReq_q, sampleReq_d;
    logic underrun_q, underrun_d;
    logic lrclk_q, lrclk_d;
    logic dacdat_q, dacdat_d;

    // Serial bit selection helpers
    logic                  inRight;
    logic [CNT_W-1:0]      slotIdx;
    logic [DATA_WIDTH-1:0] slotWord;
    logic [DATA_WIDTH-1:0] bitMask;
    logic                  serialBit;

    // Divide the system clock down to BCLK; a falling edge is a terminal count with bclk high.
    always_comb begin
        divTerm  = (divCnt_q == DIV_LAST);
        divCnt_d = divTerm ? '0 : divCnt_q + DIV_W'(1);
        bclk_d   = divTerm ? ~bclk_q : bclk_q;
        fallEdge = divTerm && bclk_q;
    end

    // Advance the frame bit counter once per BCLK falling edge, wrapping at the frame end.
    always_comb begin
        bitCnt_d   = bitCnt_q;
        frameStart = fallEdge && (bitCnt_q == CNT_LAST);
        if (fallEdge) begin
            bitCnt_d = (bitCnt_q == CNT_LAST) ? '0 : bitCnt_q + CNT_W'(1);
        end
    end

    // Holding register handshake and frame-start load; the load looks at the pre-edge register,
    // so a pair accepted on the frame-start cycle waits for the following frame.
    always_comb begin
        holdFull_d  = holdFull_q;
        holdLeft_d  = holdLeft_q;
        holdRight_d = holdRight_q;
        txLeft_d    = txLeft_q;
        txRight_d   = txRight_q;
        sampleReq_d = 1'b0;
        underrun_d  = 1'b0;
        accept      = sample_valid && !holdFull_q;

        if (frameStart) begin
            sampleReq_d = 1'b1;
            if (holdFull_q) begin
                txLeft_d   = holdLeft_q;
                txRight_d  = holdRight_q;
                holdFull_d = 1'b0;
            end else begin
                txLeft_d   = '0;
                txRight_d  = '0;
                underrun_d = 1'b1;
            end
        end

        if (accept) begin
            holdFull_d  = 1'b1;
            holdLeft_d  = audio_left_in;
            holdRight_d = audio_right_in;
        end
    end

    // Pick the serial bit for the position the counter moves to, using the words valid from this edge on.
    always_comb begin
        lrclk_d   = lrclk_q;
        dacdat_d  = dacdat_q;
        inRight   = (bitCnt_d >= SLOT_LEN);
        slotIdx   = inRight ? (bitCnt_d - SLOT_LEN) : bitCnt_d;
        slotWord  = inRight ? txRight_d : txLeft_d;
        bitMask   = '0;
`ifdef AUDIO_TX_LEFT_JUSTIFIED_EN
        if (slotIdx < WORD_LEN) begin
            bitMask = TOP_BIT >> slotIdx;
        end
`else
        if ((slotIdx >= CNT_W'(1)) && (slotIdx <= WORD_LEN)) begin
            bitMask = TOP_BIT >> (slotIdx - CNT_W'(1));
        end
`endif
        serialBit = |(slotWord & bitMask);

        if (fallEdge) begin
            lrclk_d  = inRight;
            dacdat_d = serialBit;
        end
    end

    // State register with synchronous active-low reset; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divCnt_q    <= '0;
            bclk_q      <= 1'b0;
            bitCnt_q    <= '0;
            holdFull_q  <= 1'b0;
            holdLeft_q  <= '0;
            holdRight_q <= '0;
            txLeft_q    <= '0;
            txRight_q   <= '0;
            sampleReq_q <= 1'b0;
            underrun_q  <= 1'b0;
            lrclk_q     <= 1'b0;
            dacdat_q    <= 1'b0;
        end else begin
            divCnt_q    <= divCnt_d;
            bclk_q      <= bclk_d;
            bitCnt_q    <= bitCnt_d;
            holdFull_q  <= holdFull_d;
            holdLeft_q  <= holdLeft_d;
            holdRight_q <= holdRight_d;
            txLeft_q    <= txLeft_d;
            txRight_q   <= txRight_d;
            sampleReq_q <= sampleReq_d;
            underrun_q  <= underrun_d;
            lrclk_q     <= lrclk_d;
            dacdat_q    <= dacdat_d;
        end
    end

    assign sample_ready = ~holdFull_q;
    assign sample_req   = sampleReq_q;
    assign underrun     = underrun_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign dacdat       = dacdat_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: self-checking bench for audio_dac_tx (DATA_WIDTH=16,
// SLOT_BITS=32, BCLK_DIV=2). Expected outputs come from a frame-level model:
// cycle count since reset gives clock phases and bit position, a queue stands
// in for the holding register, and slot bits follow the placement rules.
module tb_audio_dac_tx;

    localparam int DW         = 16;
    localparam int SB         = 32;
    localparam int DIV        = 2;
    localparam int FRAME_CLKS = 2 * SB * 2 * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] leftIn = '0;
    logic [DW-1:0] rightIn = '0;
    logic          valid = 1'b0;
    logic          sampleReady, sampleReq, underrunO, bclkO, lrclkO, dacdatO;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            n;
    logic [DW-1:0] curL, curR;
    logic [DW-1:0] qL[$];
    logic [DW-1:0] qR[$];
    logic [5:0]    expVec;
    logic [5:0]    obsVec;

    audio_dac_tx #(
        .DATA_WIDTH(DW),
        .SLOT_BITS (SB),
        .BCLK_DIV  (DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .audio_left_in (leftIn),
        .audio_right_in(rightIn),
        .sample_valid  (valid),
        .sample_ready  (sampleReady),
        .sample_req    (sampleReq),
        .underrun      (underrunO),
        .bclk          (bclkO),
        .lrclk         (lrclkO),
        .dacdat        (dacdatO)
    );

    always #5 clk = ~clk;

    assign obsVec = {bclkO, lrclkO, dacdatO, sampleReady, sampleReq, underrunO};

    // Expected serial bit at frame bit position b for words l/r
    function automatic logic expBit(input int b, input logic [DW-1:0] l, input logic [DW-1:0] r);
        int            k;
        logic [DW-1:0] w;
        k = b % SB;
        w = (b >= SB) ? r : l;
`ifdef AUDIO_TX_LEFT_JUSTIFIED_EN
        if (k < DW) return w[DW-1-k];
`else
        if (k >= 1 && k <= DW) return w[DW-k];
`endif
        return 1'b0;
    endfunction

    // One clock of stimulus (called at a negedge), advancing the model to the next negedge
    task automatic applyStimulus(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic acc, fs, reqE, undE;
        int   b;
        valid   = v;
        leftIn  = l;
        rightIn = r;
        acc  = v && (qL.size() == 0);
        fs   = ((n + 1) % FRAME_CLKS) == 0;
        reqE = 1'b0;
        undE = 1'b0;
        if (fs) begin
            reqE = 1'b1;
            if (qL.size() > 0) begin
                curL = qL.pop_front();
                curR = qR.pop_front();
            end else begin
                curL = '0;
                curR = '0;
                undE = 1'b1;
            end
        end
        if (acc) begin
            qL.push_back(l);
            qR.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
        n++;
        b = (n / (2 * DIV)) % (2 * SB);
        expVec = {((n / DIV) % 2) == 1, b >= SB, expBit(b, curL, curR), qL.size() == 0, reqE, undE};
    endtask

    // Hold reset for some cycles; leaves the bench at a negedge showing the reset state
    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
        n    = 0;
        curL = '0;
        curR = '0;
        qL.delete();
        qR.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset(3);
        checks++; if (bclkO !== 1'b0) begin errors++; $display("[TB] FAIL reset_bclk got=%b want=0", bclkO); end
        checks++; if (lrclkO !== 1'b0) begin errors++; $display("[TB] FAIL reset_lrclk got=%b want=0", lrclkO); end
        checks++; if (dacdatO !== 1'b0) begin errors++; $display("[TB] FAIL reset_dacdat got=%b want=0", dacdatO); end
        checks++; if (sampleReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b want=1", sampleReady); end
        checks++; if (sampleReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b want=0", sampleReq); end
        checks++; if (underrunO !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got=%b want=0", underrunO); end
    endtask

    task automatic test_idle();
        int firstReq = -1;
        repeat (600) begin
            applyStimulus(1'b0, DW'($urandom), DW'($urandom));
            checks++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL idle_outputs n=%0d got=%b want=%b", n, obsVec, expVec);
            end
            if (sampleReq === 1'b1 && firstReq < 0) firstReq = n;
        end
        checks++;
        if (firstReq !== 256) begin errors++; $display("[TB] FAIL idle_first_req got=%0d want=256", firstReq); end
    endtask

    task automatic test_known_pair();
        logic [31:0] capL = '0;
        logic [31:0] capR = '0;
        logic [31:0] wantL, wantR;
        int          unders = 0;
        int          reqs = 0;
        int          b;
`ifdef AUDIO_TX_LEFT_JUSTIFIED_EN
        wantL = 32'h8001_0000;
        wantR = 32'h7FFE_0000;
`else
        wantL = 32'h4000_8000;
        wantR = 32'h3FFF_0000;
`endif
        doReset(1);
        applyStimulus(1'b1, 16'h8001, 16'h7FFE);
        while (n < 511) begin
            applyStimulus(1'b0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL pair_outputs n=%0d got=%b want=%b", n, obsVec, expVec);
            end
            if (underrunO === 1'b1) unders++;
            if (sampleReq === 1'b1) reqs++;
            if (n >= 256 && n % (2 * DIV) == 0) begin
                b = (n / (2 * DIV)) % (2 * SB);
                if (b < SB) capL = {capL[30:0], dacdatO};
                else        capR = {capR[30:0], dacdatO};
            end
        end
        checks++; if (capL !== wantL) begin errors++; $display("[TB] FAIL pair_left_slot got=%h want=%h", capL, wantL); end
        checks++; if (capR !== wantR) begin errors++; $display("[TB] FAIL pair_right_slot got=%h want=%h", capR, wantR); end
        checks++; if (unders !== 0) begin errors++; $display("[TB] FAIL pair_underrun got=%0d want=0", unders); end
        checks++; if (reqs !== 1) begin errors++; $display("[TB] FAIL pair_req_count got=%0d want=1", reqs); end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int unders = 0;
        doReset(1);
        while (n < 11 * FRAME_CLKS - 1) begin
            if (sampleReady === 1'b1) accepts++;
            applyStimulus(1'b1, DW'($urandom), DW'($urandom));
            checks++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL b2b_outputs n=%0d got=%b want=%b", n, obsVec, expVec);
            end
            if (underrunO === 1'b1) unders++;
        end
        checks++; if (accepts !== 11) begin errors++; $display("[TB] FAIL b2b_accepts got=%0d want=11", accepts); end
        checks++; if (unders !== 0) begin errors++; $display("[TB] FAIL b2b_underrun got=%0d want=0", unders); end
    endtask

    task automatic test_late_valid();
        int            unders = 0;
        int            undAt = -1;
        logic [DW-1:0] pL, pR;
        pL = DW'($urandom) | 16'h8000;
        pR = DW'($urandom) | 16'h0001;
        doReset(1);
        while (n < 767) begin
            if (n == FRAME_CLKS - 1) applyStimulus(1'b1, pL, pR);
            else                     applyStimulus(1'b0, DW'($urandom), DW'($urandom));
            checks++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL late_outputs n=%0d got=%b want=%b", n, obsVec, expVec);
            end
            if (underrunO === 1'b1) begin
                unders++;
                undAt = n;
            end
        end
        checks++; if (unders !== 1) begin errors++; $display("[TB] FAIL late_underrun_count got=%0d want=1", unders); end
        checks++; if (undAt !== FRAME_CLKS) begin errors++; $display("[TB] FAIL late_underrun_time got=%0d want=%0d", undAt, FRAME_CLKS); end
    endtask

    task automatic test_mid_reset();
        int unders = 0;
        doReset(1);
        applyStimulus(1'b1, DW'($urandom), 16'hFFFF);
        while (n < 418) begin
            if (n == FRAME_CLKS) applyStimulus(1'b1, DW'($urandom), DW'($urandom));
            else                 applyStimulus(1'b0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL midrst_pre n=%0d got=%b want=%b", n, obsVec, expVec);
            end
        end
        doReset(1);
        checks++; if (bclkO !== 1'b0) begin errors++; $display("[TB] FAIL midrst_bclk got=%b want=0", bclkO); end
        checks++; if (lrclkO !== 1'b0) begin errors++; $display("[TB] FAIL midrst_lrclk got=%b want=0", lrclkO); end
        checks++; if (dacdatO !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dacdat got=%b want=0", dacdatO); end
        checks++; if (sampleReady !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got=%b want=1", sampleReady); end
        repeat (300) begin
            applyStimulus(1'b0, '0, '0);
            checks++;
            if (obsVec !== expVec) begin
                errors++;
                $display("[TB] FAIL midrst_post n=%0d got=%b want=%b", n, obsVec, expVec);
            end
            if (underrunO === 1'b1) unders++;
        end
        checks++; if (unders !== 1) begin errors++; $display("[TB] FAIL midrst_underrun got=%0d want=1", unders); end
    endtask

    initial begin
        n      = 0;
        curL   = '0;
        curR   = '0;
        expVec = '0;
        @(negedge clk);
        $display("[TB] reset");
        test_reset();
        $display("[TB] idle");
        test_idle();
        $display("[TB] known pair");
        test_known_pair();
        $display("[TB] back to back");
        test_back_to_back();
        $display("[TB] valid on frame start");
        test_late_valid();
        $display("[TB] reset mid frame");
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
